// File: rtl/disk_controller_spi_target.sv
// SPI mode-0 target: synchronizes sck/cs_n/mosi into clk_i, shifts bytes MSB first.
// Optional sticky overrun detection is enabled by DISK_CONTROLLER_SPI_TARGET_OVERRUN_EN.
module disk_controller_spi_target (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       sck_i,
   input  logic       cs_n_i,
   input  logic       mosi_i,
   output logic       miso_o,
   output logic       miso_oe_o,
   input  logic [7:0] dat_i,
   input  logic       load_i,
   output logic       tx_full_o,
   output logic [7:0] dat_o,
   output logic       valid_o,
   input  logic       ack_i,
   output logic       overrun_o
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t     state_reg;
   logic       sck_s1_reg, sck_s2_reg, sck_s3_reg;
   logic       cs_s1_reg, cs_s2_reg;
   logic       mosi_s1_reg, mosi_s2_reg;
   logic [1:0] warm_reg;
   logic       armed_reg;
   logic [2:0] bit_cnt_reg;
   logic [7:0] tx_sr_reg, rx_sr_reg, hold_reg, dat_reg;
   logic       tx_full_reg, valid_reg, oe_reg;

   logic       sck_rise, sck_fall, active_run, byte_done;
   logic [7:0] consume_val, rx_next;

   assign sck_rise    = sck_s2_reg & ~sck_s3_reg;
   assign sck_fall    = ~sck_s2_reg & sck_s3_reg;
   assign active_run  = (state_reg == ACTIVE) && !cs_s2_reg;
   assign byte_done   = active_run && sck_rise && (bit_cnt_reg == 3'd7);
   assign consume_val = tx_full_reg ? hold_reg : 8'hFF;
   assign rx_next     = {rx_sr_reg[6:0], mosi_s2_reg};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg   <= IDLE;
         sck_s1_reg  <= 1'b0;
         sck_s2_reg  <= 1'b0;
         sck_s3_reg  <= 1'b0;
         cs_s1_reg   <= 1'b1;
         cs_s2_reg   <= 1'b1;
         mosi_s1_reg <= 1'b0;
         mosi_s2_reg <= 1'b0;
         warm_reg    <= 2'b00;
         armed_reg   <= 1'b0;
         bit_cnt_reg <= 3'd0;
         tx_sr_reg   <= 8'hFF;
         rx_sr_reg   <= 8'h00;
         hold_reg    <= 8'h00;
         dat_reg     <= 8'h00;
         tx_full_reg <= 1'b0;
         valid_reg   <= 1'b0;
         oe_reg      <= 1'b0;
      end else begin
         sck_s1_reg  <= sck_i;
         sck_s2_reg  <= sck_s1_reg;
         sck_s3_reg  <= sck_s2_reg;
         cs_s1_reg   <= cs_n_i;
         cs_s2_reg   <= cs_s1_reg;
         mosi_s1_reg <= mosi_i;
         mosi_s2_reg <= mosi_s1_reg;
         warm_reg    <= {warm_reg[0], 1'b1};
         valid_reg   <= 1'b0;
         // Only a cs_n high level sampled after reset arms the block, so a
         // transfer interrupted by reset is not resumed mid-byte.
         if (warm_reg[1] && cs_s2_reg)
            armed_reg <= 1'b1;

         case (state_reg)
            IDLE: begin
               if (armed_reg && !cs_s2_reg) begin
                  state_reg   <= ACTIVE;
                  bit_cnt_reg <= 3'd0;
                  tx_sr_reg   <= consume_val;
                  tx_full_reg <= 1'b0;
                  oe_reg      <= 1'b1;
               end
            end
            ACTIVE: begin
               if (cs_s2_reg) begin
                  state_reg   <= IDLE;
                  bit_cnt_reg <= 3'd0;
                  oe_reg      <= 1'b0;
               end else if (sck_rise) begin
                  rx_sr_reg   <= rx_next;
                  bit_cnt_reg <= bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) begin
                     dat_reg   <= rx_next;
                     valid_reg <= 1'b1;
                  end
               end else if (sck_fall) begin
                  if (bit_cnt_reg != 3'd0) begin
                     tx_sr_reg <= {tx_sr_reg[6:0], 1'b0};
                  end else begin
                     tx_sr_reg   <= consume_val;
                     tx_full_reg <= 1'b0;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase

         // A load in the same cycle as a consume overrides the clear.
         if (load_i) begin
            hold_reg    <= dat_i;
            tx_full_reg <= 1'b1;
         end
      end
   end

   assign miso_o    = tx_sr_reg[7];
   assign miso_oe_o = oe_reg;
   assign tx_full_o = tx_full_reg;
   assign dat_o     = dat_reg;
   assign valid_o   = valid_reg;

`ifdef DISK_CONTROLLER_SPI_TARGET_OVERRUN_EN
   logic pending_reg, overrun_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pending_reg <= 1'b0;
         overrun_reg <= 1'b0;
      end else if (byte_done) begin
         pending_reg <= 1'b1;
         if (pending_reg && !ack_i)
            overrun_reg <= 1'b1;
      end else if (ack_i) begin
         pending_reg <= 1'b0;
      end
   end

   assign overrun_o = overrun_reg;
`else
   logic unused_ack;
   logic unused_done;
   assign unused_ack  = ack_i;
   assign unused_done = byte_done;
   assign overrun_o   = 1'b0;
`endif

endmodule

// File: tb/tb_disk_controller_spi_target.sv
// Directed bench for disk_controller_spi_target: bit-level SPI initiator plus a byte-queue model.
module tb_disk_controller_spi_target;

   logic       clk = 1'b0;
   logic       rst_i, sck_i, cs_n_i, mosi_i;
   logic       miso_o, miso_oe_o;
   logic [7:0] dat_i;
   logic       load_i, tx_full_o;
   logic [7:0] dat_o;
   logic       valid_o, ack_i, overrun_o;

   int         total = 0;
   int         bad = 0;
   int         valid_cnt = 0;
   int         v0;
   logic [7:0] exp_q[$];
   bit         m_pending = 1'b0;
   bit         m_overrun = 1'b0;

   always #5 clk = ~clk;

   disk_controller_spi_target dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .sck_i     (sck_i),
      .cs_n_i    (cs_n_i),
      .mosi_i    (mosi_i),
      .miso_o    (miso_o),
      .miso_oe_o (miso_oe_o),
      .dat_i     (dat_i),
      .load_i    (load_i),
      .tx_full_o (tx_full_o),
      .dat_o     (dat_o),
      .valid_o   (valid_o),
      .ack_i     (ack_i),
      .overrun_o (overrun_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Model: every completed byte must appear once on dat_o with valid_o, in order.
   always @(negedge clk) begin
      if (!rst_i) begin
         if (valid_o) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
               check("valid_o_unexpected", valid_o, 1'b0);
            end else begin
               check("dat_o_model", dat_o, exp_q.pop_front());
            end
`ifdef DISK_CONTROLLER_SPI_TARGET_OVERRUN_EN
            if (m_pending) m_overrun = 1'b1;
            m_pending = 1'b1;
`endif
         end
         check("overrun_model", overrun_o, m_overrun);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_byte(input logic [7:0] d);
      dat_i  = d;
      load_i = 1'b1;
      clks(1);
      load_i = 1'b0;
   endtask

   task automatic ack_pulse();
      ack_i     = 1'b1;
      m_pending = 1'b0;
      clks(1);
      ack_i = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso_oe"}, miso_oe_o, 1'b0);
      check({tag, "_tx_full"}, tx_full_o, 1'b0);
      check({tag, "_dat_o"},   dat_o,     8'h00);
      check({tag, "_valid"},   valid_o,   1'b0);
      check({tag, "_overrun"}, overrun_o, 1'b0);
      check({tag, "_miso"},    miso_o,    1'b1);
   endtask

   task automatic cs_low();
      cs_n_i = 1'b0;
      clks(6);
   endtask

   task automatic cs_high();
      cs_n_i = 1'b1;
      clks(8);
   endtask

   // One full byte; miso is sampled just before each rising sck edge.
   task automatic spi_byte(input logic [7:0] m, input logic [7:0] expm,
                           input bit inj, input logic [7:0] injd);
      logic [7:0] got;
      got = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         mosi_i = m[i];
         clks(6);
         got[i] = miso_o;
         check("miso_bit", miso_o, expm[i]);
         sck_i = 1'b1;
         if (i == 0) exp_q.push_back(m);
         clks(6);
         sck_i = 1'b0;
         if (i == 0 && inj) begin
            // The fall is acted on at the third rising clk edge after it.
            clks(2);
            dat_i  = injd;
            load_i = 1'b1;
            clks(1);
            load_i = 1'b0;
         end
      end
      $display("byte: mosi=%02h miso=%02h", m, got);
   endtask

   task automatic partial(input int n, input logic [7:0] m);
      for (int i = 0; i < n; i++) begin
         mosi_i = m[7 - i];
         clks(6);
         sck_i = 1'b1;
         clks(6);
         sck_i = 1'b0;
      end
   endtask

   initial begin
      rst_i  = 1'b1;
      sck_i  = 1'b0;
      cs_n_i = 1'b1;
      mosi_i = 1'b0;
      dat_i  = 8'h00;
      load_i = 1'b0;
      ack_i  = 1'b0;
      clks(3);
      check_reset_outputs("reset");
      rst_i = 1'b0;
      clks(5);

      // Loaded byte goes out while 8'h3C is received
      load_byte(8'hA5);
      check("t1_tx_full_loaded", tx_full_o, 1'b1);
      cs_n_i = 1'b0;
      clks(2);
      check("t1_tx_full_pre", tx_full_o, 1'b1);
      check("t1_oe_pre", miso_oe_o, 1'b0);
      clks(1);
      check("t1_tx_full_post", tx_full_o, 1'b0);
      check("t1_oe_post", miso_oe_o, 1'b1);
      clks(3);
      v0 = valid_cnt;
      spi_byte(8'h3C, 8'hA5, 1'b0, 8'h00);
      clks(6);
      check("t1_valid_cnt", valid_cnt - v0, 1);
      check("t1_dat_o", dat_o, 8'h3C);
      cs_high();
      check("t1_oe_off", miso_oe_o, 1'b0);
      ack_pulse();

      // Two bytes in one window; second has no load behind it
      load_byte(8'h5A);
      cs_low();
      v0 = valid_cnt;
      spi_byte(8'h12, 8'h5A, 1'b0, 8'h00);
      spi_byte(8'h34, 8'hFF, 1'b0, 8'h00);
      clks(6);
      check("t2_valid_cnt", valid_cnt - v0, 2);
      check("t2_dat_o", dat_o, 8'h34);
      cs_high();

      // Abort after 5 rises; holding register survives the abort
      cs_low();
      load_byte(8'h77);
      v0 = valid_cnt;
      partial(5, 8'hF0);
      cs_high();
      check("t3_abort_valid", valid_cnt - v0, 0);
      check("t3_tx_full_kept", tx_full_o, 1'b1);
      cs_low();
      spi_byte(8'h81, 8'h77, 1'b0, 8'h00);
      clks(6);
      check("t3_valid_cnt", valid_cnt - v0, 1);
      check("t3_dat_o", dat_o, 8'h81);
      cs_high();

      // Load coinciding with the byte-boundary consume
      cs_low();
      load_byte(8'h11);
      spi_byte(8'hA0, 8'hFF, 1'b1, 8'h55);
      check("t4_tx_full_after_inj", tx_full_o, 1'b1);
      spi_byte(8'hB1, 8'h11, 1'b0, 8'h00);
      clks(4);
      check("t4_tx_full_drained", tx_full_o, 1'b0);
      spi_byte(8'hC2, 8'h55, 1'b0, 8'h00);
      clks(6);
      cs_high();

      // Two unacknowledged bytes after a clean reset
      rst_i = 1'b1;
      exp_q.delete();
      m_pending = 1'b0;
      m_overrun = 1'b0;
      clks(1);
      rst_i = 1'b0;
      clks(5);
      cs_low();
      spi_byte(8'h01, 8'hFF, 1'b0, 8'h00);
      spi_byte(8'h02, 8'hFF, 1'b0, 8'h00);
      clks(6);
      check("t5_dat_o", dat_o, 8'h02);
`ifdef DISK_CONTROLLER_SPI_TARGET_OVERRUN_EN
      check("t5_overrun", overrun_o, 1'b1);
`else
      check("t5_overrun", overrun_o, 1'b0);
`endif
      cs_high();

      // Reset at bit 4 with cs_n held low
      cs_low();
      partial(4, 8'hAA);
      rst_i = 1'b1;
      exp_q.delete();
      m_pending = 1'b0;
      m_overrun = 1'b0;
      clks(1);
      check_reset_outputs("t6_rst");
      rst_i = 1'b0;
      v0 = valid_cnt;
      clks(3);
      partial(8, 8'h5A);
      clks(6);
      check("t6_no_valid", valid_cnt - v0, 0);
      check("t6_oe_held_off", miso_oe_o, 1'b0);
      cs_high();
      cs_low();
      spi_byte(8'hC3, 8'hFF, 1'b0, 8'h00);
      clks(6);
      check("t6_valid_cnt", valid_cnt - v0, 1);
      check("t6_dat_o", dat_o, 8'hC3);
      cs_high();

      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
